// File: rtl/line_follow_pkg.sv
// Shared encodings for the line-follow controller: FSM states, motor codes,
// sensor patterns and the pattern classifier.
package line_follow_pkg;

    typedef enum logic [2:0] {
        StStop   = 3'd0,
        StFwd    = 3'd1,
        StLeft   = 3'd2,
        StRight  = 3'd3,
        StSearch = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ClsNone,
        ClsHold,
        ClsFwd,
        ClsLeft,
        ClsRight
    } cls_e;

    // Motor bit order: left_motor1, left_motor2, right_motor1, right_motor2
    localparam logic [3:0] MotorFwd   = 4'b1010;
    localparam logic [3:0] MotorLeft  = 4'b0110;
    localparam logic [3:0] MotorRight = 4'b1001;
    localparam logic [3:0] MotorOff   = 4'b0000;

    // Sensor pattern {left, centre, right}, 1 = line seen
    localparam logic [2:0] PatNone        = 3'b000;
    localparam logic [2:0] PatRight       = 3'b001;
    localparam logic [2:0] PatCentre      = 3'b010;
    localparam logic [2:0] PatRightCentre = 3'b011;
    localparam logic [2:0] PatLeft        = 3'b100;
    localparam logic [2:0] PatOuter       = 3'b101;
    localparam logic [2:0] PatLeftCentre  = 3'b110;
    localparam logic [2:0] PatAll         = 3'b111;

    function automatic cls_e classify(input logic [2:0] pat);
        cls_e c;
        case (pat)
            PatCentre, PatAll:           c = ClsFwd;
            PatLeft, PatLeftCentre:      c = ClsLeft;
            PatRight, PatRightCentre:    c = ClsRight;
            PatNone:                     c = ClsNone;
            default:                     c = ClsHold;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/line_follow_controller_if.sv
// Sensor, command and motor-drive signals of the line-follow controller.
interface line_follow_controller_if;
    logic       start;
    logic       ir_sensor1;
    logic       ir_sensor2;
    logic       ir_sensor3;
    logic       left_motor1;
    logic       left_motor2;
    logic       right_motor1;
    logic       right_motor2;
    logic       ena;
    logic       enb;
    logic [2:0] state;
    logic       lost;

    // Controller side
    modport master (
        input  start, ir_sensor1, ir_sensor2, ir_sensor3,
        output left_motor1, left_motor2, right_motor1, right_motor2,
        output ena, enb, state, lost
    );

    // Robot / environment side
    modport slave (
        output start, ir_sensor1, ir_sensor2, ir_sensor3,
        input  left_motor1, left_motor2, right_motor1, right_motor2,
        input  ena, enb, state, lost
    );
endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer: the accepted
// pattern only changes after DEBOUNCE consecutive identical synchronised samples.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned WIDTH    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] accepted
);
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    run_len;

    // Length of the current run of equal samples including this one, saturating
    always_comb begin
        if (sync2 != cand) begin
            run_len = CW'(1);
        end else if (cnt == CW'(DEBOUNCE)) begin
            run_len = cnt;
        end else begin
            run_len = cnt + CW'(1);
        end
    end

    // Synchroniser, run tracking and accepted-pattern register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            cnt      <= '0;
            accepted <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cand  <= sync2;
            cnt   <= run_len;
            if (run_len == CW'(DEBOUNCE)) begin
                accepted <= sync2;
            end
        end
    end

endmodule

// File: rtl/line_follow_controller.sv
// Line-follow steering controller: debounced sensors drive a forward / left /
// right / search / stop FSM, with H-bridge direction decode and PWM enables.
module line_follow_controller
    import line_follow_pkg::*;
#(
    parameter int unsigned PWM_PERIOD     = 100,
    parameter int unsigned DUTY_FWD       = 55,
    parameter int unsigned DUTY_TURN      = 40,
    parameter int unsigned DEBOUNCE       = 4,
    parameter int unsigned SEARCH_TIMEOUT = 50000
) (
    input logic                      clk,
    input logic                      rst,
    line_follow_controller_if.master bus
);
    localparam int unsigned TW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int unsigned PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    logic [2:0]    pat_a;
    cls_e          cls;
    state_e        target;
    state_e        state_q;
    state_e        state_d;
    logic          lost_q;
    logic          lost_d;
    logic          side_left_q;
    logic [TW-1:0] timer_q;
    logic          timeout;
    logic [PW-1:0] pwm_cnt;
    logic [31:0]   duty_q;
    logic          en_q;
    logic [3:0]    motors;

    function automatic logic [31:0] duty_for(input state_e s);
        logic [31:0] d;
        case (s)
            StStop:  d = 32'd0;
            StFwd:   d = 32'(DUTY_FWD);
            default: d = 32'(DUTY_TURN);
        endcase
        return d;
    endfunction

    sensor_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .WIDTH    (3)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .raw      ({bus.ir_sensor1, bus.ir_sensor2, bus.ir_sensor3}),
        .accepted (pat_a)
    );

    assign timeout = (timer_q == TW'(SEARCH_TIMEOUT - 1));

    // Next state: a steering pattern always wins over the search timeout
    always_comb begin
        cls     = classify(pat_a);
        state_d = state_q;
        lost_d  = lost_q;
        case (cls)
            ClsFwd:   target = StFwd;
            ClsLeft:  target = StLeft;
            ClsRight: target = StRight;
            default:  target = StSearch;
        endcase
        case (state_q)
            StStop: begin
                if (bus.start) begin
                    state_d = target;
                    lost_d  = 1'b0;
                end
            end
            StFwd, StLeft, StRight: begin
                if (cls != ClsHold) begin
                    state_d = target;
                end
            end
            StSearch: begin
                if (cls == ClsFwd || cls == ClsLeft || cls == ClsRight) begin
                    state_d = target;
                end else if (timeout) begin
                    state_d = StStop;
                    lost_d  = 1'b1;
                end
            end
            default: state_d = StStop;
        endcase
    end

    // FSM state, sticky lost flag, last turn side and search timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StStop;
            lost_q      <= 1'b0;
            side_left_q <= 1'b1;
            timer_q     <= '0;
        end else begin
            state_q <= state_d;
            lost_q  <= lost_d;
            if (state_d == StLeft) begin
                side_left_q <= 1'b1;
            end else if (state_d == StRight) begin
                side_left_q <= 1'b0;
            end
            if (state_q == StSearch && state_d == StSearch) begin
                timer_q <= timer_q + TW'(1);
            end else begin
                timer_q <= '0;
            end
        end
    end

    // PWM counter; duty only changes at wrap, but STOP kills the enable at once
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            en_q <= (state_d != StStop) && (32'(pwm_cnt) < duty_q);
            if (pwm_cnt == PW'(PWM_PERIOD - 1)) begin
                pwm_cnt <= '0;
                duty_q  <= duty_for(state_d);
            end else begin
                pwm_cnt <= pwm_cnt + PW'(1);
            end
        end
    end

    // Direction bits decode straight from the state register
    always_comb begin
        case (state_q)
            StFwd:    motors = MotorFwd;
            StLeft:   motors = MotorLeft;
            StRight:  motors = MotorRight;
            StSearch: motors = side_left_q ? MotorLeft : MotorRight;
            default:  motors = MotorOff;
        endcase
    end

    assign bus.left_motor1  = motors[3];
    assign bus.left_motor2  = motors[2];
    assign bus.right_motor1 = motors[1];
    assign bus.right_motor2 = motors[0];
    assign bus.ena          = en_q;
    assign bus.enb          = en_q;
    assign bus.state        = state_q;
    assign bus.lost         = lost_q;

endmodule

// File: tb/tb_line_follow_controller.sv
// Bench for line_follow_controller: directed scenarios plus a randomized
// sensor walk, all compared each cycle against a behavioural model.
module tb_line_follow_controller;
    localparam int unsigned PWM_PERIOD     = 100;
    localparam int unsigned DUTY_FWD       = 55;
    localparam int unsigned DUTY_TURN      = 40;
    localparam int unsigned DEBOUNCE       = 4;
    localparam int unsigned SEARCH_TIMEOUT = 20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_follow_controller_if bus();

    line_follow_controller #(
        .PWM_PERIOD     (PWM_PERIOD),
        .DUTY_FWD       (DUTY_FWD),
        .DUTY_TURN      (DUTY_TURN),
        .DEBOUNCE       (DEBOUNCE),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [2:0] m_s1, m_s2, m_a;
    logic [2:0] sq[$];
    int         m_state, m_timer, m_phase, m_duty;
    bit         m_side_left, m_lost, m_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Steering target of an accepted pattern: 1..3 state, 0 no line, -1 ambiguous
    function automatic int target_of(input logic [2:0] a);
        case (a)
            3'b010, 3'b111: return 1;
            3'b100, 3'b110: return 2;
            3'b001, 3'b011: return 3;
            3'b000:         return 0;
            default:        return -1;
        endcase
    endfunction

    function automatic int duty_of(input int s);
        if (s == 0) return 0;
        if (s == 1) return DUTY_FWD;
        return DUTY_TURN;
    endfunction

    function automatic logic [3:0] exp_motors(input int s, input bit side_left);
        case (s)
            1:       return 4'b1010;
            2:       return 4'b0110;
            3:       return 4'b1001;
            4:       return side_left ? 4'b0110 : 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_step();
        int  t, ns;
        bit  nlost, all_eq;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_a = '0; sq.delete();
            m_state = 0; m_timer = 0; m_lost = 0; m_side_left = 1;
            m_phase = 0; m_duty = 0; m_en = 0;
            return;
        end
        t     = target_of(m_a);
        ns    = m_state;
        nlost = m_lost;
        if (m_state == 0) begin
            if (bus.start) begin
                nlost = 0;
                ns    = (t > 0) ? t : 4;
            end
        end else if (m_state == 4) begin
            if (t > 0) ns = t;
            else if (m_timer == int'(SEARCH_TIMEOUT) - 1) begin
                ns    = 0;
                nlost = 1;
            end
        end else begin
            if (t > 0) ns = t;
            else if (t == 0) ns = 4;
        end
        m_timer = (ns == 4 && m_state == 4) ? m_timer + 1 : 0;
        if (ns == 2) m_side_left = 1;
        if (ns == 3) m_side_left = 0;
        m_en = (ns != 0) && (m_phase < m_duty);
        if (m_phase == int'(PWM_PERIOD) - 1) begin
            m_phase = 0;
            m_duty  = duty_of(ns);
        end else begin
            m_phase++;
        end
        m_state = ns;
        m_lost  = nlost;
        // Accept a pattern once the last DEBOUNCE synchronised samples agree
        sq.push_back(m_s2);
        if (sq.size() > int'(DEBOUNCE)) void'(sq.pop_front());
        if (sq.size() == int'(DEBOUNCE)) begin
            all_eq = 1;
            foreach (sq[i]) if (sq[i] != sq[0]) all_eq = 0;
            if (all_eq) m_a = sq[0];
        end
        m_s2 = m_s1;
        m_s1 = {bus.ir_sensor1, bus.ir_sensor2, bus.ir_sensor3};
    endtask

    function automatic logic [3:0] dut_motors();
        return {bus.left_motor1, bus.left_motor2, bus.right_motor1, bus.right_motor2};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("state", 32'(bus.state), 32'(m_state));
        chk("motors", 32'(dut_motors()), 32'(exp_motors(m_state, m_side_left)));
        chk("ena", 32'(bus.ena), 32'(m_en));
        chk("enb", 32'(bus.enb), 32'(m_en));
        chk("lost", 32'(bus.lost), 32'(m_lost));
    endtask

    task automatic set_pat(input logic [2:0] p);
        bus.ir_sensor1 = p[2];
        bus.ir_sensor2 = p[1];
        bus.ir_sensor3 = p[0];
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic count_window(output int na, output int nb);
        na = 0;
        nb = 0;
        repeat (PWM_PERIOD) begin
            tick();
            na += int'(bus.ena);
            nb += int'(bus.enb);
        end
    endtask

    task automatic chk_all_off(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 0);
        chk({tag, "_motors"}, 32'(dut_motors()), 0);
        chk({tag, "_ena"}, 32'(bus.ena), 0);
        chk({tag, "_enb"}, 32'(bus.enb), 0);
        chk({tag, "_lost"}, 32'(bus.lost), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, n;
        bit stayed;
        logic [2:0] p;
        int len;

        rst = 1'b1;
        bus.start = 1'b0;
        set_pat(3'b010);
        tick();
        chk_all_off("reset1");
        bus.start = 1'b1;  // rst overrides start
        tick();
        chk_all_off("reset2");
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (10) tick();
        chk_all_off("idle");

        pulse_start();
        chk("start_state", 32'(bus.state), 1);
        chk("start_motors", 32'(dut_motors()), 32'(4'b1010));
        repeat (200) tick();
        count_window(na, nb);
        chk("fwd_duty_ena", 32'(na), 55);
        chk("fwd_duty_enb", 32'(nb), 55);

        // Left turn lands exactly seven edges after the raw change
        set_pat(3'b100);
        repeat (6) tick();
        chk("turn_latency_before", 32'(bus.state), 1);
        tick();
        chk("turn_latency", 32'(bus.state), 2);
        chk("left_motors", 32'(dut_motors()), 32'(4'b0110));
        repeat (200) tick();
        count_window(na, nb);
        chk("turn_duty_ena", 32'(na), 40);

        // Short loss of line is filtered out
        set_pat(3'b010);
        repeat (10) tick();
        chk("back_fwd", 32'(bus.state), 1);
        set_pat(3'b000);
        repeat (3) tick();
        set_pat(3'b010);
        stayed = 1;
        repeat (15) begin
            tick();
            if (bus.state != 3'd1) stayed = 0;
        end
        chk("glitch_ignored", 32'(stayed), 1);

        // Right, then lose the line: search toward the right, then time out
        set_pat(3'b001);
        repeat (10) tick();
        chk("right_state", 32'(bus.state), 3);
        set_pat(3'b000);
        n = 0;
        while (bus.state != 3'd4 && n < 20) begin
            tick();
            n++;
        end
        chk("search_entry_latency", 32'(n), 7);
        chk("search_motors", 32'(dut_motors()), 32'(4'b1001));
        n = 0;
        while (bus.state != 3'd0 && n < int'(SEARCH_TIMEOUT) + 10) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(SEARCH_TIMEOUT));
        chk("timeout_lost", 32'(bus.lost), 1);
        chk("timeout_ena", 32'(bus.ena), 0);
        chk("timeout_enb", 32'(bus.enb), 0);

        // Restart with no line, then make the pattern land on the timeout cycle
        pulse_start();
        chk("restart_search", 32'(bus.state), 4);
        chk("restart_lost_clr", 32'(bus.lost), 0);
        repeat (SEARCH_TIMEOUT - 7) tick();
        set_pat(3'b010);
        repeat (6) tick();
        chk("race_pre", 32'(bus.state), 4);
        tick();
        chk("race_state", 32'(bus.state), 1);
        chk("race_lost", 32'(bus.lost), 0);

        // Ambiguous pattern holds the current turn
        set_pat(3'b100);
        repeat (10) tick();
        chk("left_again", 32'(bus.state), 2);
        set_pat(3'b101);
        stayed = 1;
        repeat (20) begin
            tick();
            if (bus.state != 3'd2) stayed = 0;
        end
        chk("hold_101", 32'(stayed), 1);

        // Reset in the middle of a PWM period
        set_pat(3'b100);
        repeat (137) tick();
        rst = 1'b1;
        tick();
        chk_all_off("midrst");
        chk("midrst_pwm_cnt", 32'(dut.pwm_cnt), 0);
        rst = 1'b0;

        // Randomized sensor walk with occasional start pulses and resets
        repeat (300) begin
            p   = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 12);
            set_pat(p);
            rst       = ($urandom_range(0, 79) == 0);
            bus.start = ($urandom_range(0, 5) == 0);
            tick();
            rst       = 1'b0;
            bus.start = 1'b0;
            repeat (len - 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
